// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding,
// requester count/width, and the priority-search result type.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;
endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder shared by arbitration blocks.
module decoder3_8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);

  // Combinational binary-to-one-hot decode
  always_comb begin
    case (sel)
      3'd0:    dec = 8'h01;
      3'd1:    dec = 8'h02;
      3'd2:    dec = 8'h04;
      3'd3:    dec = 8'h08;
      3'd4:    dec = 8'h10;
      3'd5:    dec = 8'h20;
      3'd6:    dec = 8'h40;
      3'd7:    dec = 8'h80;
      default: dec = 8'h00;
    endcase
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold-until-release grants and 1-cycle latency.
// Optional owner time-out preemption is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);
  import arb_pkg::*;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD out of range 2..255");
  end

  logic [0:0]      state_r, state_next_s;
  logic [ID_W-1:0] ptr_r, ptr_next_s;
  logic [ID_W-1:0] gnt_id_r, gnt_id_next_s;
  logic            gnt_valid_r, gnt_valid_next_s;
  logic [N_REQ-1:0] dec_s;
  logic [N_REQ-1:0] search_req_s;
  logic [ID_W-1:0]  search_ptr_s;
  pick_t            pick_s;
  logic             release_s;
  logic             preempt_s;

  // First set bit of r in the order p, p+1, ..., p+7 (mod 8)
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    pick_t           res;
    logic [ID_W-1:0] idx;
    logic            hit;
    res.found = 1'b0;
    res.id    = {ID_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx       = p + i[ID_W-1:0];
      hit       = r[idx];
      res.found = res.found | hit;
      res.id    = hit ? idx : res.id;
    end
    return res;
  endfunction

  decoder3_8 u_dec (
    .sel (gnt_id_r),
    .dec (dec_s)
  );

  // While owning, search starts just past the owner and never re-picks the owner.
  assign search_ptr_s = (state_r == GRANT) ? gnt_id_r + 3'd1 : ptr_r;
  assign search_req_s = (state_r == GRANT) ? (req & ~dec_s) : req;
  assign pick_s       = rr_pick(search_req_s, search_ptr_s);
  assign release_s    = ~req[gnt_id_r] | preempt_s;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_r;
  logic       hold_done_s;

  // Counter value is (grant cycles so far - 1); the limit is hit in the MAX_HOLD-th cycle.
  assign hold_done_s = (hold_cnt_r >= 8'(MAX_HOLD - 1));
  assign preempt_s   = hold_done_s & (|(req & ~dec_s));

  // Per-owner grant-cycle counter, cleared on every new grant, saturating at MAX_HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= 8'd0;
    end else if (state_r != GRANT || release_s) begin
      hold_cnt_r <= 8'd0;
    end else if (hold_cnt_r < 8'(MAX_HOLD)) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end
`else
  assign preempt_s = 1'b0;
`endif

  // Next-state, pointer and grant selection
  always_comb begin
    state_next_s     = state_r;
    ptr_next_s       = ptr_r;
    gnt_id_next_s    = gnt_id_r;
    gnt_valid_next_s = gnt_valid_r;
    case (state_r)
      IDLE: begin
        if (pick_s.found) begin
          state_next_s     = GRANT;
          gnt_id_next_s    = pick_s.id;
          gnt_valid_next_s = 1'b1;
        end else begin
          state_next_s     = IDLE;
          gnt_id_next_s    = 3'd0;
          gnt_valid_next_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          ptr_next_s = search_ptr_s;
          if (pick_s.found) begin
            state_next_s     = GRANT;
            gnt_id_next_s    = pick_s.id;
            gnt_valid_next_s = 1'b1;
          end else begin
            state_next_s     = IDLE;
            gnt_id_next_s    = 3'd0;
            gnt_valid_next_s = 1'b0;
          end
        end else begin
          state_next_s = GRANT;
        end
      end
      default: begin
        state_next_s     = IDLE;
        gnt_id_next_s    = 3'd0;
        gnt_valid_next_s = 1'b0;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      gnt_id_r    <= 3'd0;
      gnt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ptr_r       <= ptr_next_s;
      gnt_id_r    <= gnt_id_next_s;
      gnt_valid_r <= gnt_valid_next_s;
    end
  end

  assign gnt       = dec_s & {N_REQ{gnt_valid_r}};
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;

endmodule
